// File: rtl/uart_pkg.sv
// Shared state encodings and line constants for the bus-attached UART.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int   FRAME_BITS = 10;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_core.sv
// Purpose: 8N1 deserialiser with 2-FF rxd synchroniser, start-bit glitch reject, mid-bit sampling.
// Latency: byte_vld_o/stop_err_o are combinational strobes in the cycle the stop bit is sampled.
// Backpressure: none; the caller must take every strobe as it happens.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 rxd_i,
    output logic                 byte_vld_o,
    output logic                 stop_err_o,
    output logic [DATA_BITS-1:0] byte_dat_o
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q, prev_q;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bitidx_q, bitidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q  <= IDLE_LEVEL;
            sync2_q  <= IDLE_LEVEL;
            prev_q   <= IDLE_LEVEL;
            state_q  <= RX_IDLE;
            timer_q  <= '0;
            bitidx_q <= '0;
            shift_q  <= '0;
        end else begin
            sync1_q  <= rxd_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitidx_q <= bitidx_d;
            shift_q  <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bitidx_d   = bitidx_q;
        shift_d    = shift_q;
        byte_vld_o = 1'b0;
        stop_err_o = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    timer_d = '0;
                end
            end
            RX_START: begin
                // Start bit must still be low half a bit in, otherwise treat it as line noise.
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d  = RX_DATA;
                        bitidx_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d = '0;
                    shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                    if (bitidx_q == B_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bitidx_d = bitidx_q + BW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RX_STOP: begin
                if (timer_q == T_LAST) begin
                    timer_d    = '0;
                    state_d    = RX_IDLE;
                    byte_vld_o = sync2_q;
                    stop_err_o = !sync2_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_dat_o = shift_q;

endmodule

// File: rtl/uart_port_responder.sv
// Purpose: bus-attached UART answering rdn/wrn strobes; THR/TSR transmit path and RBR receive path.
// Latency: write edge -> tbre low next cycle, txd start bit two cycles after the edge; RBR valid the cycle after the stop sample.
// Backpressure: writes while THR is full are dropped; unread RBR is overwritten with an overrun pulse.
module uart_port_responder
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 rdn,
    input  logic                 wrn,
    inout  wire  [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 tbre,
    output logic                 tsre,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rdn_q, wrn_q;
    tx_state_t            tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_timer_q, tx_timer_d;
    logic [BW-1:0]        tx_bitidx_q, tx_bitidx_d;
    logic [DATA_BITS-1:0] tsr_q, tsr_d;
    logic [DATA_BITS-1:0] thr_q, thr_d;
    logic [DATA_BITS-1:0] rbr_q, rbr_d;
    logic                 txd_q, txd_d;
    logic                 tbre_q, tbre_d;
    logic                 tsre_q, tsre_d;
    logic                 data_ready_q, data_ready_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q, overrun_d;

    logic                 wr_edge, rd_rise, thr_take, wr_ok;
    logic                 rx_vld, rx_err;
    logic [DATA_BITS-1:0] rx_dat;

    uart_rx_core #(
        .BAUD_DIV  (BAUD_DIV),
        .DATA_BITS (DATA_BITS)
    ) u_rx (
        .CLK        (CLK),
        .RST        (RST),
        .rxd_i      (rxd),
        .byte_vld_o (rx_vld),
        .stop_err_o (rx_err),
        .byte_dat_o (rx_dat)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rdn_q         <= 1'b1;
            wrn_q         <= 1'b1;
            tx_state_q    <= TX_IDLE;
            tx_timer_q    <= '0;
            tx_bitidx_q   <= '0;
            tsr_q         <= '0;
            thr_q         <= '0;
            rbr_q         <= '0;
            txd_q         <= IDLE_LEVEL;
            tbre_q        <= 1'b1;
            tsre_q        <= 1'b1;
            data_ready_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rdn_q         <= rdn;
            wrn_q         <= wrn;
            tx_state_q    <= tx_state_d;
            tx_timer_q    <= tx_timer_d;
            tx_bitidx_q   <= tx_bitidx_d;
            tsr_q         <= tsr_d;
            thr_q         <= thr_d;
            rbr_q         <= rbr_d;
            txd_q         <= txd_d;
            tbre_q        <= tbre_d;
            tsre_q        <= tsre_d;
            data_ready_q  <= data_ready_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign wr_edge = !wrn && wrn_q;
    assign rd_rise = rdn && !rdn_q;

    // Transmit FSM; txd is registered, so each transition sets the level for the next bit.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_timer_d  = tx_timer_q;
        tx_bitidx_d = tx_bitidx_q;
        tsr_d       = tsr_q;
        txd_d       = txd_q;
        tsre_d      = tsre_q;
        thr_take    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tbre_q) begin
                    thr_take   = 1'b1;
                    tx_state_d = TX_START;
                    tx_timer_d = '0;
                    tsr_d      = thr_q;
                    txd_d      = 1'b0;
                    tsre_d     = 1'b0;
                end
            end
            TX_START: begin
                if (tx_timer_q == T_LAST) begin
                    tx_timer_d  = '0;
                    tx_bitidx_d = '0;
                    tx_state_d  = TX_DATA;
                    txd_d       = tsr_q[0];
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            TX_DATA: begin
                if (tx_timer_q == T_LAST) begin
                    tx_timer_d = '0;
                    if (tx_bitidx_q == B_LAST) begin
                        tx_state_d = TX_STOP;
                        txd_d      = IDLE_LEVEL;
                    end else begin
                        tx_bitidx_d = tx_bitidx_q + BW'(1);
                        tsr_d       = tsr_q >> 1;
                        txd_d       = tsr_q[1];
                    end
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            TX_STOP: begin
                if (tx_timer_q == T_LAST) begin
                    tx_timer_d = '0;
                    // A pending THR starts the next frame straight out of the stop bit.
                    if (!tbre_q) begin
                        thr_take   = 1'b1;
                        tx_state_d = TX_START;
                        tsr_d      = thr_q;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tsre_d     = 1'b1;
                    end
                end else begin
                    tx_timer_d = tx_timer_q + TW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // THR and receive-side bookkeeping; a write racing a THR->TSR move lands behind it.
    always_comb begin
        thr_d         = thr_q;
        tbre_d        = tbre_q;
        rbr_d         = rbr_q;
        data_ready_d  = data_ready_q;
        wr_ok         = wr_edge && (tbre_q || thr_take);
        if (wr_ok) begin
            thr_d  = data;
            tbre_d = 1'b0;
        end else if (thr_take) begin
            tbre_d = 1'b1;
        end
        if (rx_vld) begin
            rbr_d        = rx_dat;
            data_ready_d = 1'b1;
        end else if (rd_rise) begin
            data_ready_d = 1'b0;
        end
        overrun_d     = rx_vld && data_ready_q && !rd_rise;
        framing_err_d = rx_err;
    end

    assign data        = rdn ? {DATA_BITS{1'bz}} : rbr_q;
    assign txd         = txd_q;
    assign tbre        = tbre_q;
    assign tsre        = tsre_q;
    assign data_ready  = data_ready_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_port_responder.sv
// Directed bench: stimulus pushes expected TX bytes and RX events into queues; monitors pop and compare.
module tb_uart_port_responder;
    import uart_pkg::*;

    localparam int BD = 16;
    localparam int EV_RDY  = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVR  = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rdn, wrn;
    wire  [7:0] data;
    logic [7:0] drv_dat;
    logic       drv_en;
    logic       data_ready, tbre, tsre, txd, framing_err, overrun;
    logic       rxd_drv, loop_en;
    wire        rxd;
    logic       tx_mon_off;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tx_q[$];
    int         rx_q[$];

    assign data = drv_en ? drv_dat : 8'hzz;
    assign rxd  = loop_en ? txd : rxd_drv;

    always #5 CLK = ~CLK;

    uart_port_responder dut (
        .CLK         (CLK),
        .RST         (RST),
        .rdn         (rdn),
        .wrn         (wrn),
        .data        (data),
        .data_ready  (data_ready),
        .tbre        (tbre),
        .tsre        (tsre),
        .txd         (txd),
        .rxd         (rxd),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] v);
        @(negedge CLK);
        drv_dat = v;
        drv_en  = 1'b1;
        wrn     = 1'b0;
        @(negedge CLK);
        wrn    = 1'b1;
        drv_en = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [7:0] exp);
        @(negedge CLK);
        rdn = 1'b0;
        @(negedge CLK);
        check(nm, data, exp);
        rdn = 1'b1;
        @(negedge CLK);
        check({nm, "_clr"}, data_ready, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int k = 0; k < FRAME_BITS; k++) begin
            @(negedge CLK);
            rxd_drv = fr[k];
            repeat (BD - 1) @(negedge CLK);
        end
        @(negedge CLK);
        rxd_drv = 1'b1;
    endtask

    task automatic wait_dr(input string nm, input int bound);
        int i;
        i = 0;
        while (!data_ready && i < bound) begin
            @(negedge CLK);
            i++;
        end
        check(nm, data_ready, 1'b1);
    endtask

    task automatic rx_event(input int kind);
        int e;
        if (rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got event %0d, expected none", kind);
        end else begin
            e = rx_q.pop_front();
            check("rx_event", kind, e);
        end
    endtask

    // Serial decoder on txd: finds a start edge, samples mid-bit, compares against tx_q.
    initial begin : tx_mon
        logic [7:0] b;
        logic       startb, stopb, prev, skip;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (prev && !txd) begin
                skip = tx_mon_off;
                repeat (BD / 2) @(negedge CLK);
                startb = txd;
                for (int k = 0; k < 8; k++) begin
                    repeat (BD) @(negedge CLK);
                    b[k] = txd;
                end
                repeat (BD) @(negedge CLK);
                stopb = txd;
                if (!skip) begin
                    if (tx_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got frame %0h, expected none", b);
                    end else begin
                        check("tx_byte", b, tx_q.pop_front());
                        check("tx_start_stop", {startb, stopb}, 2'b01);
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin : rx_mon
        logic dr_prev;
        dr_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (data_ready && !dr_prev) rx_event(EV_RDY);
            if (framing_err) rx_event(EV_FERR);
            if (overrun) rx_event(EV_OVR);
            dr_prev = data_ready;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [9:0] exp_bits;
        int         cnt, w;
        RST = 1'b0; rdn = 1'b1; wrn = 1'b1; drv_en = 1'b0; drv_dat = 8'h00;
        rxd_drv = 1'b1; loop_en = 1'b0; tx_mon_off = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_txd", txd, 1'b1);
        check("rst_tbre", tbre, 1'b1);
        check("rst_tsre", tsre, 1'b1);
        check("rst_flags", {data_ready, framing_err, overrun}, 3'b000);
        RST = 1'b1;

        // Reset in the middle of a TX frame and a partial RX frame.
        wr(8'h00);
        @(negedge CLK);
        rxd_drv = 1'b0;
        repeat (60) @(negedge CLK);
        check("busy_tsre", tsre, 1'b0);
        RST = 1'b0;
        #1;
        check("midrst_txd", txd, 1'b1);
        check("midrst_tbre_tsre", {tbre, tsre}, 2'b11);
        check("midrst_dr", data_ready, 1'b0);
        rxd_drv = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (200) @(negedge CLK);
        check("postrst_dr", data_ready, 1'b0);
        tx_mon_off = 1'b0;

        // Single write of A5: exact bit timing.
        tx_q.push_back(8'hA5);
        exp_bits = 10'b11_0100_1010;
        wr(8'hA5);
        check("wr_tbre_n1", tbre, 1'b0);
        @(negedge CLK);
        check("wr_tbre_n2", tbre, 1'b1);
        check("wr_txd_n2", txd, 1'b0);
        check("wr_tsre_n2", tsre, 1'b0);
        repeat (BD / 2) @(negedge CLK);
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (k > 0) repeat (BD) @(negedge CLK);
            check($sformatf("a5_bit%0d", k), txd, exp_bits[k]);
        end
        repeat (7) @(negedge CLK);
        check("a5_tsre_before", tsre, 1'b0);
        @(negedge CLK);
        check("a5_tsre_done", tsre, 1'b1);
        repeat (5) @(negedge CLK);

        // Back-to-back 11/22, 33 dropped while THR full.
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        fork
            begin
                wr(8'h11);
                repeat (20) @(negedge CLK);
                wr(8'h22);
                check("b2b_tbre_22", tbre, 1'b0);
                repeat (10) @(negedge CLK);
                wr(8'h33);
                check("b2b_tbre_33", tbre, 1'b0);
            end
            begin
                w = 0;
                while (tsre && w < 50) begin
                    @(negedge CLK);
                    w++;
                end
                cnt = 0;
                while (!tsre && cnt < 1000) begin
                    @(negedge CLK);
                    cnt++;
                end
                check("b2b_busy_cycles", cnt, 320);
            end
        join
        repeat (200) @(negedge CLK);
        check("b2b_tsre_idle", tsre, 1'b1);

        // RX byte 3C, read and clear.
        rx_q.push_back(EV_RDY);
        send_frame(8'h3C, 1'b1);
        wait_dr("rx3c_ready", 40);
        rd_check("rx3c_data", 8'h3C);

        // Glitch rejected, then framing error.
        @(negedge CLK);
        rxd_drv = 1'b0;
        repeat (4) @(negedge CLK);
        rxd_drv = 1'b1;
        repeat (40) @(negedge CLK);
        check("glitch_dr", data_ready, 1'b0);
        rx_q.push_back(EV_FERR);
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge CLK);
        check("ferr_dr", data_ready, 1'b0);

        // Overrun: 01 then 02 unread.
        rx_q.push_back(EV_RDY);
        send_frame(8'h01, 1'b1);
        rx_q.push_back(EV_OVR);
        send_frame(8'h02, 1'b1);
        repeat (5) @(negedge CLK);
        check("ovr_dr", data_ready, 1'b1);
        rd_check("ovr_data", 8'h02);

        // Loopback txd -> rxd.
        loop_en = 1'b1;
        tx_q.push_back(8'hC3);
        rx_q.push_back(EV_RDY);
        wr(8'hC3);
        wait_dr("loop_ready", 250);
        rd_check("loop_data", 8'hC3);
        loop_en = 1'b0;

        repeat (50) @(negedge CLK);
        check("tx_q_drained", tx_q.size(), 0);
        check("rx_q_drained", rx_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
